// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - regfile port-A owner that stalls the CPU and streams r0..rN-1 out
// Optional running sum of accepted beats when DUMP_SUM_EN is defined.
module regfile_dump_ctrl #(
    parameter int NUM_REGS      = 32,
    parameter int REG_AW        = 5,
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_req,
    input  logic [REG_AW-1:0] cpu_readRegA,
    output logic [REG_AW-1:0] ctrl_readRegA,
    input  logic [DATA_W-1:0] data_readRegA,
    output logic              cpu_stall,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_AW-1:0] dump_reg,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
`ifdef DUMP_SUM_EN
    output logic              dump_done,
    output logic [DATA_W-1:0] dump_sum
`else
    output logic              dump_done
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << REG_AW)) begin : g_bad_regs
        $error("NUM_REGS must lie in 2..2**REG_AW");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_ADDR,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [REG_AW-1:0] idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [REG_AW-1:0] reg_q;
    logic [DATA_W-1:0] data_q;
`ifdef DUMP_SUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
`ifdef DUMP_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dump_req) begin
                        state_q <= S_STALL;
`ifdef DUMP_SUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                // One dead cycle so the CPU has frozen before port A is taken over.
                S_STALL: begin
                    state_q <= S_ADDR;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                end
                S_ADDR: begin
                    if (cnt_q == LAST_CNT) begin
                        data_q  <= data_readRegA;
                        reg_q   <= idx_q;
                        cnt_q   <= '0;
                        state_q <= S_PRESENT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (dump_ready) begin
`ifdef DUMP_SUM_EN
                        sum_q <= sum_q + data_q;
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + REG_AW'(1);
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Address mux is combinational so the CPU keeps zero-latency reads while idle.
    assign ctrl_readRegA = (state_q == S_IDLE) ? cpu_readRegA : idx_q;

    assign dump_busy  = (state_q != S_IDLE);
    assign cpu_stall  = (state_q != S_IDLE);
    assign dump_valid = (state_q == S_PRESENT);
    assign dump_done  = (state_q == S_DONE);
    assign dump_reg   = reg_q;
    assign dump_data  = data_q;
`ifdef DUMP_SUM_EN
    assign dump_sum   = sum_q;
`endif

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - self-checking bench for regfile_dump_ctrl
// Checks dump_sum as well when built with DUMP_SUM_EN.
module tb_regfile_dump_ctrl;

    localparam int NR = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        dump_req;
    logic [4:0]  cpu_readRegA;
    logic [4:0]  ctrl_readRegA;
    logic [31:0] data_readRegA;
    logic        cpu_stall;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_reg;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;
`ifdef DUMP_SUM_EN
    logic [31:0] dump_sum;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  reg_i;
        logic [31:0] data;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic [4:0] cpu;
        logic [4:0] exp_ctrl;
    } idle_vec_t;

    always #5 clock = ~clock;

    // Regfile model: ri = i*3
    always_comb data_readRegA = 32'(ctrl_readRegA) * 32'd3;

    regfile_dump_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .dump_req      (dump_req),
        .cpu_readRegA  (cpu_readRegA),
        .ctrl_readRegA (ctrl_readRegA),
        .data_readRegA (data_readRegA),
        .cpu_stall     (cpu_stall),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_reg      (dump_reg),
        .dump_data     (dump_data),
        .dump_busy     (dump_busy),
`ifdef DUMP_SUM_EN
        .dump_done     (dump_done),
        .dump_sum      (dump_sum)
`else
        .dump_done     (dump_done)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && dump_valid && dump_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got reg %0d, expected no beat", dump_reg);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_reg", 64'(dump_reg), 64'(e.reg_i));
                chk("beat_data", 64'(dump_data), 64'(e.data));
            end
        end
    end

    task automatic push_dump();
        for (int i = 0; i < NR; i++) begin
            beat_t b;
            b.reg_i = 5'(i);
            b.data  = 32'(i * 3);
            sb.push_back(b);
        end
    endtask

    // Pulses dump_req; returns #1 after the sampling edge E0.
    task automatic start_dump();
        @(posedge clock); #1 dump_req = 1'b1;
        @(posedge clock); #1 dump_req = 1'b0;
    endtask

    task automatic wait_beat(input int r);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (dump_valid && dump_reg == 5'(r)) ok = 1'b1;
        end
        chk($sformatf("wait_beat_%0d", r), 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (dump_done) ok = 1'b1;
        end
        chk("wait_done", 64'(ok), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_vec_t vecs[4];
        int first_valid, done_cnt, done_at, idle_at;
        int d1, d2;
        logic stall_h[300];

        vecs[0] = '{cpu: 5'd7,  exp_ctrl: 5'd7};
        vecs[1] = '{cpu: 5'd0,  exp_ctrl: 5'd0};
        vecs[2] = '{cpu: 5'd31, exp_ctrl: 5'd31};
        vecs[3] = '{cpu: 5'd19, exp_ctrl: 5'd19};

        reset = 1'b1; dump_req = 1'b0; cpu_readRegA = 5'd0; dump_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_busy", 64'(dump_busy), 64'd0);
        chk("rst_done", 64'(dump_done), 64'd0);
        chk("rst_reg", 64'(dump_reg), 64'd0);
        chk("rst_data", 64'(dump_data), 64'd0);
        @(posedge clock); #1 reset = 1'b0;

        // Idle passthrough table
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1 cpu_readRegA = vecs[i].cpu;
            @(negedge clock);
            chk("idle_ctrl", 64'(ctrl_readRegA), 64'(vecs[i].exp_ctrl));
            chk("idle_stall", 64'(cpu_stall), 64'd0);
            chk("idle_valid", 64'(dump_valid), 64'd0);
        end

        // Full dump with ready tied high, latency checks
        push_dump();
        start_dump();
        first_valid = -1; done_cnt = 0; done_at = -1; idle_at = -1;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clock);
            if (c == 0) begin
                chk("e0_stall", 64'(cpu_stall), 64'd1);
                chk("e0_addr_mux", 64'(ctrl_readRegA), 64'd0);
            end
            if (dump_valid && first_valid < 0) first_valid = c;
            if (dump_done) begin
                done_cnt++;
                done_at = c;
`ifdef DUMP_SUM_EN
                chk("dump_sum", 64'(dump_sum), 64'd1488);
`endif
            end
            if (!cpu_stall && idle_at < 0) idle_at = c;
        end
        chk("first_valid_cycle", 64'(first_valid), 64'd2);
        chk("done_cycle", 64'(done_at), 64'd65);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("idle_cycle", 64'(idle_at), 64'd66);
        chk("sb_empty_full", 64'(sb.size()), 64'd0);

        // Backpressure on beat 4
        push_dump();
        start_dump();
        wait_beat(3);
        @(posedge clock); #1 dump_ready = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_valid", 64'(dump_valid), 64'd1);
            chk("bp_reg", 64'(dump_reg), 64'd4);
            chk("bp_data", 64'(dump_data), 64'd12);
        end
        @(posedge clock); #1 dump_ready = 1'b1;
        wait_done();
        chk("sb_empty_bp", 64'(sb.size()), 64'd0);

        // Reset during beat 10
        push_dump();
        start_dump();
        wait_beat(9);
        @(posedge clock); #1 reset = 1'b1; cpu_readRegA = 5'd13;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
        chk("mid_rst_valid", 64'(dump_valid), 64'd0);
        chk("mid_rst_busy", 64'(dump_busy), 64'd0);
        chk("mid_rst_data", 64'(dump_data), 64'd0);
        chk("mid_rst_ctrl", 64'(ctrl_readRegA), 64'd13);
        sb.delete();
        @(posedge clock); #1 reset = 1'b0;
        push_dump();
        start_dump();
        wait_done();
        chk("sb_empty_rst", 64'(sb.size()), 64'd0);

        // dump_req held high through two dumps
        push_dump();
        push_dump();
        for (int c = 0; c < 300; c++) stall_h[c] = 1'bx;
        d1 = -1; d2 = -1;
        @(posedge clock); #1 dump_req = 1'b1;
        for (int c = 0; c < 300 && d2 < 0; c++) begin
            @(negedge clock);
            stall_h[c] = cpu_stall;
            if (dump_done) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    dump_req = 1'b0;
                end
            end
        end
        dump_req = 1'b0;
        chk("held_second_done_seen", 64'(d2 >= 0), 64'd1);
        chk("held_done_interval", 64'(d2 - d1), 64'd67);
        chk("held_gap_stall", 64'((d1 >= 0 && d1 < 290) ? stall_h[d1 + 1] : 1'bx), 64'd0);
        chk("held_restart_stall", 64'((d1 >= 0 && d1 < 290) ? stall_h[d1 + 2] : 1'bx), 64'd1);
        repeat (3) @(negedge clock);
        chk("held_final_stall", 64'(cpu_stall), 64'd0);
        chk("sb_empty_held", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
